// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter and busy scoreboard for the 4x32 register file
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   req0_valid/reg/data/ready   ALU result write request; ready is the combinational grant
//   req1_valid/reg/data/ready   load/memory return write request; ready is the combinational grant
//   alloc_valid, alloc_reg      issue logic reserving a destination register
//   regWrite, writereg,
//   writedata                   registered write port into the register file
//   busy                        per-register write-outstanding scoreboard
//   err                         sticky protocol error flag
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [1:0]  req0_reg,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        alloc_valid,
    input  logic [1:0]  alloc_reg,
    output logic        regWrite,
    output logic [1:0]  writereg,
    output logic [31:0] writedata,
    output logic [3:0]  busy,
    output logic        err
);

    // 0 favours requester 0 under contention, 1 favours requester 1
    logic       prio;
    logic       xfer;
    logic [3:0] set_mask;
    logic [3:0] clr_mask;
    logic       alloc_err;
    logic       write_err;

    // Grants depend only on valids and the pointer, never on each other
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            req0_ready = req0_valid && (!req1_valid || !prio);
            req1_ready = req1_valid && (!req0_valid ||  prio);
        end
    end

    assign xfer = req0_ready || req1_ready;

    assign set_mask = alloc_valid ? (4'b0001 << alloc_reg) : 4'b0000;
    assign clr_mask = regWrite    ? (4'b0001 << writereg)  : 4'b0000;

    // Re-allocating a busy register is legal only when its write retires this same cycle
    assign alloc_err = alloc_valid && busy[alloc_reg] && !clr_mask[alloc_reg];
    assign write_err = regWrite && !busy[writereg];

    always_ff @(posedge clk) begin
        if (reset) begin
            prio      <= 1'b0;
            regWrite  <= 1'b0;
            writereg  <= 2'd0;
            writedata <= 32'd0;
            busy      <= 4'b0000;
            err       <= 1'b0;
        end else begin
            regWrite <= xfer;
            if (req0_ready) begin
                writereg  <= req0_reg;
                writedata <= req0_data;
                prio      <= 1'b1;
            end else if (req1_ready) begin
                writereg  <= req1_reg;
                writedata <= req1_data;
                prio      <= 1'b0;
            end
            // Set is applied after clear so a same-cycle set wins
            busy <= (busy & ~clr_mask) | set_mask;
            if (alloc_err || write_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic [1:0]  req0_reg = 2'd0;
    logic [31:0] req0_data = 32'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [1:0]  req1_reg = 2'd0;
    logic [31:0] req1_data = 32'd0;
    logic        req1_ready;
    logic        alloc_valid = 1'b0;
    logic [1:0]  alloc_reg = 2'd0;
    logic        regWrite;
    logic [1:0]  writereg;
    logic [31:0] writedata;
    logic [3:0]  busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
        .regWrite(regWrite), .writereg(writereg), .writedata(writedata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state of the write-back path
    int          m_prio = 0;
    bit          m_we = 0;
    int          m_wreg = 0;
    bit [31:0]   m_wdata = 0;
    bit          m_busy[4] = '{0, 0, 0, 0};
    bit          m_err = 0;

    // Which requester should win right now: -1 none, else 0 or 1
    function automatic int winner();
        if (reset) return -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_prio = 0; m_we = 0; m_wreg = 0; m_wdata = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_busy[i] = 0;
        end else begin
            w = winner();
            if (alloc_valid && m_busy[alloc_reg] && !(m_we && m_wreg == int'(alloc_reg))) m_err = 1;
            if (m_we && !m_busy[m_wreg]) m_err = 1;
            if (m_we) m_busy[m_wreg] = 0;
            if (alloc_valid) m_busy[alloc_reg] = 1;
            if (w == 0) begin
                m_we = 1; m_wreg = int'(req0_reg); m_wdata = req0_data; m_prio = 1;
            end else if (w == 1) begin
                m_we = 1; m_wreg = int'(req1_reg); m_wdata = req1_data; m_prio = 0;
            end else begin
                m_we = 0;
            end
        end
    end

    // Every cycle, mid low phase: DUT vs model
    always @(negedge clk) begin
        int w;
        logic [3:0] eb;
        #2;
        w = winner();
        eb = {m_busy[3], m_busy[2], m_busy[1], m_busy[0]};
        chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
        chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
        chk("m_regWrite", {31'd0, regWrite}, {31'd0, m_we});
        chk("m_writereg", {30'd0, writereg}, m_wreg);
        chk("m_writedata", writedata, m_wdata);
        chk("m_busy", {28'd0, busy}, {28'd0, eb});
        chk("m_err", {31'd0, err}, {31'd0, m_err});
    end

    // One cycle of stimulus, then settle so literal checks can follow
    task automatic cyc(input logic r,
                       input logic v0, input logic [1:0] g0, input logic [31:0] d0,
                       input logic v1, input logic [1:0] g1, input logic [31:0] d1,
                       input logic av, input logic [1:0] ar);
        @(negedge clk);
        reset = r;
        req0_valid = v0; req0_reg = g0; req0_data = d0;
        req1_valid = v1; req1_reg = g1; req1_data = d1;
        alloc_valid = av; alloc_reg = ar;
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset with requests pending: grants must stay low
        cyc(1, 1, 1, 32'h5, 1, 2, 32'h6, 0, 0);
        chk("rst_ready0", {31'd0, req0_ready}, 0);
        chk("rst_ready1", {31'd0, req1_ready}, 0);
        idle();
        chk("idle_regWrite", {31'd0, regWrite}, 0);
        chk("idle_writereg", {30'd0, writereg}, 0);
        chk("idle_writedata", writedata, 0);
        chk("idle_busy", {28'd0, busy}, 0);
        chk("idle_err", {31'd0, err}, 0);
        chk("idle_ready", {30'd0, req1_ready, req0_ready}, 0);

        // Single write
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("sw_ready0", {31'd0, req0_ready}, 1);
        idle();
        chk("sw_regWrite", {31'd0, regWrite}, 1);
        chk("sw_writereg", {30'd0, writereg}, 2);
        chk("sw_writedata", writedata, 32'hDEADBEEF);
        chk("sw_busy_set", {31'd0, busy[2]}, 1);
        idle();
        chk("sw_busy_clr", {31'd0, busy[2]}, 0);
        chk("sw_err", {31'd0, err}, 0);
        chk("sw_regWrite_off", {31'd0, regWrite}, 0);
        chk("sw_writedata_hold", writedata, 32'hDEADBEEF);

        // Contention: alternation starting from req0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, 32'h11, 1, 3, 32'h33, 0, 0);
            chk("ct_ready0", {31'd0, req0_ready}, (k % 2 == 0) ? 1 : 0);
            chk("ct_ready1", {31'd0, req1_ready}, (k % 2 == 1) ? 1 : 0);
            if (k > 0) chk("ct_writereg", {30'd0, writereg}, (k % 2 == 1) ? 1 : 3);
        end
        idle();
        chk("ct_writereg_last", {30'd0, writereg}, 3);
        chk("ct_writedata_last", writedata, 32'h33);

        // Set/clear collision on reg 1
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 32'hA5A5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("col_regWrite", {31'd0, regWrite}, 1);
        idle();
        chk("col_busy1", {31'd0, busy[1]}, 1);
        chk("col_err", {31'd0, err}, 0);

        // Double alloc error; write still performed
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h77, 0, 0);
        chk("da_err", {31'd0, err}, 1);
        idle();
        chk("da_regWrite", {31'd0, regWrite}, 1);
        chk("da_writereg", {30'd0, writereg}, 0);

        // Write without alloc
        do_reset();
        cyc(0, 1, 3, 32'h99, 0, 0, 0, 0, 0);
        idle();
        chk("wna_regWrite", {31'd0, regWrite}, 1);
        chk("wna_writereg", {30'd0, writereg}, 3);
        chk("wna_err_pre", {31'd0, err}, 0);
        idle();
        chk("wna_err", {31'd0, err}, 1);

        // Reset mid-flight
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 1, 2, 32'h1234, 0, 0);
        chk("mf_ready1", {31'd0, req1_ready}, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mf_inflight", {31'd0, regWrite}, 1);
        idle();
        chk("mf_regWrite", {31'd0, regWrite}, 0);
        chk("mf_busy", {28'd0, busy}, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
